shared_aes_io: RTL and testbench
================================

# shared_aes_io

Parametrised I/O controller for the masked, round-based AES core. It collects plaintext and key shares over a narrow serial port and optionally re-masks them with fresh randomness. It then starts the core, and streams the shared ciphertext back out over the same narrow format with a valid/ready handshake. It generalises the fixed 2-share, 1-byte-per-beat loading sequence to any share count and lane width, and adds output serialisation and backpressure.

## Interface
- NSHARES, 2, number of Boolean shares (>= 2)
- LANE_BYTES, 1, bytes per share per beat; must be 1, 2, 4, 8 or 16
- REFRESH, 1, 1 = re-mask input shares while loading; 0 = pass through unchanged
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- go  in  1  start request; sampled only in IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  high in LOAD
- pt_in  in  8·LANE_BYTES·NSHARES  plaintext beat; share s at [s·8·LANE_BYTES +: 8·LANE_BYTES]
- key_in  in  8·LANE_BYTES·NSHARES  key beat, same layout
- rnd  in  16·LANE_BYTES·(NSHARES−1)  fresh randomness; low half for pt, high half for key
- core_start  out  1  one-cycle start pulse to the core
- core_pt, core_key  out  128·NSHARES  parallel shared state; share s at [s·128 +: 128]
- core_done  in  1  core completion pulse
- core_ct  in  128·NSHARES  shared ciphertext, valid with core_done
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat accepted
- out_data  out  8·LANE_BYTES·NSHARES  ciphertext beat, same layout as pt_in
- out_last  out  1  marks the final output beat
- busy  out  1  high in every state except IDLE

## Operation
- BEATS = 16/LANE_BYTES. Beat 0 carries state bytes 0..LANE_BYTES−1. Byte 0 is bits [127:120] of each share.
- The FSM has five states: IDLE, LOAD, START, WAIT, UNLOAD.
- IDLE → LOAD when go=1. This clears the beat counter.
- LOAD:
  - A beat is accepted when in_valid & in_ready.
  - Each accepted beat shifts into per-share 128-bit registers, MSB-first.
  - After BEATS accepted beats → START.
- Refresh (REFRESH=1), applied to each accepted beat:
  - Shares 0..N−2 are XORed with their rnd chunk.
  - Share N−1 is XORed with the XOR of all chunks.
  - The unshared value is therefore unchanged.
  - With REFRESH=0, rnd is ignored.
- START: core_start=1 for exactly one cycle → WAIT.
- WAIT:
  - On core_done, core_ct is latched into the output shift register → UNLOAD.
  - core_done outside WAIT is ignored.
- UNLOAD:
  - out_valid=1 and out_data = the current top lane of each share.
  - Each out_valid & out_ready shifts one lane.
  - out_last=1 on beat BEATS−1. Its acceptance → IDLE.
- core_pt and core_key hold their value from START until the next go is accepted.
- go is ignored outside IDLE. in_valid is ignored outside LOAD.
- Reset, at any time including mid-operation:
  - state → IDLE, counter → 0, all data registers → 0.
  - Every output is 0 (in_ready, core_start, out_valid, out_last, busy, core_pt, core_key, out_data).

## Timing
- go sampled at edge t → in_ready=1 from cycle t+1.
- Minimum load: BEATS cycles with in_valid held high. There are no bubbles inserted by the block.
- Last load beat accepted at edge k → core_start=1 in cycle k+1, with core_pt and core_key already final.
- core_done sampled at edge d → out_valid=1 from cycle d+1.
- Throughput is one beat per cycle under continuous valid and ready.
- out_data is stable while out_valid & !out_ready.
- Fixed overhead outside the core: BEATS + 1 + 1 + BEATS cycles.

## Structure
- Package shared_aes_pkg holds:
  - BLOCK_BITS=128 and BYTE_BITS=8.
  - The state enum (IDLE, LOAD, START, WAIT, UNLOAD).
  - A beats(LANE_BYTES) function.
  - An elaboration check for legal LANE_BYTES values.
- Sub-module share_shift_reg, parametrised by width, lane width and share count:
  - parallel load, lane shift-in and lane shift-out.
  - Three instances: pt, key and ct.
- The refresh XOR network lives inline in shared_aes_io.

## Test plan
- N=2, L=1, REFRESH=0: go, then 16 beats of zeros → core_pt and core_key are all zero. A stub core returns ct share0=66E94BD4EF8A2C3B884CFA59CA342B2E, share1=0 → output beats 0x0066, 0x00E9, … (16 beats), with out_last on the 16th.
- N=2, L=1, REFRESH=1, random rnd, all-zero pt and key → the XOR of the core_pt shares is 0, the XOR of the core_key shares is 0, and share0 ≠ 0 for nonzero rnd.
- N=3, L=4: 4 load beats and 4 unload beats. Random out_ready backpressure → out_data holds while stalled, and the recombined ciphertext matches the stub.
- go pulsed during LOAD and WAIT, and core_done pulsed during LOAD → no state change; the beat count still reaches BEATS.
- reset asserted mid-UNLOAD (beat 5) → all outputs are 0 in the same cycle. After release, a new go runs a clean transaction.
- in_valid gaps during LOAD (every other cycle) → core_start occurs exactly one cycle after the 16th accepted beat.

Source files
------------

// File: rtl/shared_aes_pkg.sv
// rtl/shared_aes_pkg.sv - shared constants, FSM state type and parameter helpers for shared_aes_io
package shared_aes_pkg;
    localparam int BLOCK_BITS = 128;
    localparam int BYTE_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        UNLOAD
    } state_t;

    function automatic int beats(input int lane_bytes);
        return 16 / lane_bytes;
    endfunction

    function automatic bit lane_bytes_legal(input int lane_bytes);
        return (lane_bytes == 1) || (lane_bytes == 2) || (lane_bytes == 4) ||
               (lane_bytes == 8) || (lane_bytes == 16);
    endfunction
endpackage

// File: rtl/share_shift_reg.sv
// rtl/share_shift_reg.sv - per-share register with parallel load and lane-wide left shift
module share_shift_reg #(
    parameter int WIDTH   = 128,
    parameter int LANE    = 8,
    parameter int NSHARES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [WIDTH*NSHARES-1:0] load_data,
    input  logic                     shift_en,
    input  logic [LANE*NSHARES-1:0]  shift_data,
    output logic [WIDTH*NSHARES-1:0] q
);
    logic [WIDTH*NSHARES-1:0] data_q, data_d;

    // New lanes enter at the LSB end, so the first lane shifted in ends up on top.
    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = load_data;
        end else if (shift_en) begin
            for (int s = 0; s < NSHARES; s++) begin
                data_d[s*WIDTH +: WIDTH] = (data_q[s*WIDTH +: WIDTH] << LANE) |
                                           WIDTH'(shift_data[s*LANE +: LANE]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;
endmodule

// File: rtl/shared_aes_io.sv
// rtl/shared_aes_io.sv - serial share loader with optional re-masking, core launcher and ciphertext unloader
module shared_aes_io
    import shared_aes_pkg::*;
#(
    parameter int NSHARES    = 2,
    parameter int LANE_BYTES = 1,
    parameter int REFRESH    = 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           go,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [BYTE_BITS*LANE_BYTES*NSHARES-1:0]        pt_in,
    input  logic [BYTE_BITS*LANE_BYTES*NSHARES-1:0]        key_in,
    input  logic [2*BYTE_BITS*LANE_BYTES*(NSHARES-1)-1:0]  rnd,
    output logic                                           core_start,
    output logic [BLOCK_BITS*NSHARES-1:0]                  core_pt,
    output logic [BLOCK_BITS*NSHARES-1:0]                  core_key,
    input  logic                                           core_done,
    input  logic [BLOCK_BITS*NSHARES-1:0]                  core_ct,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [BYTE_BITS*LANE_BYTES*NSHARES-1:0]        out_data,
    output logic                                           out_last,
    output logic                                           busy
);
    localparam int LW    = BYTE_BITS * LANE_BYTES;
    localparam int BW    = LW * NSHARES;
    localparam int SW    = BLOCK_BITS * NSHARES;
    localparam int RH    = LW * (NSHARES - 1);
    localparam int BEATS = beats(LANE_BYTES);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!lane_bytes_legal(LANE_BYTES)) begin : g_lane_bytes_check
        $error("LANE_BYTES must be 1, 2, 4, 8 or 16");
    end

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_fire, ct_load, ct_shift;
    logic [BW-1:0]  pt_mix, key_mix;
    logic [LW-1:0]  pt_acc, key_acc;
    logic [SW-1:0]  ct_q;
    logic           unused_ct_tail;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (go) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_d = UNLOAD;
                    cnt_d   = '0;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == LAST_BEAT);
                if (out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_fire  = in_ready & in_valid;
    assign ct_load  = (state_q == WAIT) & core_done;
    assign ct_shift = out_valid & out_ready;

    // Last share absorbs every chunk so the XOR across shares is preserved.
    always_comb begin
        pt_mix  = pt_in;
        key_mix = key_in;
        pt_acc  = '0;
        key_acc = '0;
        if (REFRESH != 0) begin
            for (int s = 0; s < NSHARES - 1; s++) begin
                pt_mix[s*LW +: LW]  = pt_in[s*LW +: LW] ^ rnd[s*LW +: LW];
                key_mix[s*LW +: LW] = key_in[s*LW +: LW] ^ rnd[RH + s*LW +: LW];
                pt_acc  = pt_acc ^ rnd[s*LW +: LW];
                key_acc = key_acc ^ rnd[RH + s*LW +: LW];
            end
            pt_mix[(NSHARES-1)*LW +: LW]  = pt_in[(NSHARES-1)*LW +: LW] ^ pt_acc;
            key_mix[(NSHARES-1)*LW +: LW] = key_in[(NSHARES-1)*LW +: LW] ^ key_acc;
        end
    end

    share_shift_reg #(.WIDTH(BLOCK_BITS), .LANE(LW), .NSHARES(NSHARES)) u_pt (
        .clk        (clk),
        .rst        (reset),
        .load_en    (1'b0),
        .load_data  ({SW{1'b0}}),
        .shift_en   (in_fire),
        .shift_data (pt_mix),
        .q          (core_pt)
    );

    share_shift_reg #(.WIDTH(BLOCK_BITS), .LANE(LW), .NSHARES(NSHARES)) u_key (
        .clk        (clk),
        .rst        (reset),
        .load_en    (1'b0),
        .load_data  ({SW{1'b0}}),
        .shift_en   (in_fire),
        .shift_data (key_mix),
        .q          (core_key)
    );

    share_shift_reg #(.WIDTH(BLOCK_BITS), .LANE(LW), .NSHARES(NSHARES)) u_ct (
        .clk        (clk),
        .rst        (reset),
        .load_en    (ct_load),
        .load_data  (core_ct),
        .shift_en   (ct_shift),
        .shift_data ({BW{1'b0}}),
        .q          (ct_q)
    );

    for (genvar s = 0; s < NSHARES; s++) begin : g_out_lane
        assign out_data[s*LW +: LW] = ct_q[s*BLOCK_BITS + BLOCK_BITS - LW +: LW];
    end

    assign unused_ct_tail = ^ct_q;
endmodule

// File: tb/tb_shared_aes_io.sv
// tb/tb_shared_aes_io.sv - table-driven and randomized checks of shared_aes_io against a byte-level model
module tb_shared_aes_io;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic         a_go = 0, a_in_valid = 0, a_core_done = 0, a_out_ready = 0;
    logic [15:0]  a_pt_in = '0, a_key_in = '0, a_rnd = '0;
    logic [255:0] a_core_ct = '0;
    logic         a_in_ready, a_core_start, a_out_valid, a_out_last, a_busy;
    logic [255:0] a_core_pt, a_core_key;
    logic [15:0]  a_out_data;

    logic         b_go = 0, b_in_valid = 0, b_core_done = 0, b_out_ready = 0;
    logic [95:0]  b_pt_in = '0, b_key_in = '0;
    logic [127:0] b_rnd = '0;
    logic [383:0] b_core_ct = '0;
    logic         b_in_ready, b_core_start, b_out_valid, b_out_last, b_busy;
    logic [383:0] b_core_pt, b_core_key;
    logic [95:0]  b_out_data;

    shared_aes_io #(.NSHARES(2), .LANE_BYTES(1), .REFRESH(1)) dut_a (
        .clk(clk), .reset(rst), .go(a_go), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .pt_in(a_pt_in), .key_in(a_key_in), .rnd(a_rnd), .core_start(a_core_start),
        .core_pt(a_core_pt), .core_key(a_core_key), .core_done(a_core_done), .core_ct(a_core_ct),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy)
    );

    shared_aes_io #(.NSHARES(3), .LANE_BYTES(4), .REFRESH(0)) dut_b (
        .clk(clk), .reset(rst), .go(b_go), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pt_in(b_pt_in), .key_in(b_key_in), .rnd(b_rnd), .core_start(b_core_start),
        .core_pt(b_core_pt), .core_key(b_core_key), .core_done(b_core_done), .core_ct(b_core_ct),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy)
    );

    typedef struct {
        logic [127:0] ct0;
        logic [127:0] ct1;
        logic [15:0]  first_beat;
        logic [15:0]  last_beat;
    } kat_t;
    kat_t kat [3];

    logic [15:0] a_ptb [16];
    logic [15:0] a_keyb [16];
    logic [15:0] a_rndb [16];
    logic [95:0] b_ptb [4];
    logic [95:0] b_keyb [4];

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Share s byte k is byte k of input share s XOR its mask; with two shares both use the same chunk.
    function automatic logic [255:0] a_model(input bit key);
        logic [255:0] r;
        logic [15:0]  v;
        logic [7:0]   m;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            v = key ? a_keyb[k] : a_ptb[k];
            m = key ? a_rndb[k][15:8] : a_rndb[k][7:0];
            r[127 - 8*k -: 8] = v[7:0] ^ m;
            r[255 - 8*k -: 8] = v[15:8] ^ m;
        end
        return r;
    endfunction

    function automatic logic [383:0] b_model(input bit key);
        logic [383:0] r;
        logic [95:0]  v;
        r = '0;
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                v = key ? b_keyb[b] : b_ptb[b];
                r[s*128 + 96 - 32*b +: 32] = v[s*32 +: 32];
            end
        end
        return r;
    endfunction

    task automatic a_load(input bit gaps, input bit noise);
        int acc = 0;
        int cyc = 0;
        int early = 0;
        bit fire;
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        chk("a_in_ready_after_go", a_in_ready, 1);
        while (acc < 16 && cyc < 100) begin
            a_in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            a_pt_in    = a_in_valid ? a_ptb[acc]  : 16'($urandom);
            a_key_in   = a_in_valid ? a_keyb[acc] : 16'($urandom);
            a_rnd      = a_in_valid ? a_rndb[acc] : 16'($urandom);
            if (noise) begin
                a_go        = 1'($urandom);
                a_core_done = 1'($urandom);
            end
            fire = a_in_valid && a_in_ready;
            if (a_core_start) early++;
            tick();
            if (fire) acc++;
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_go        = 1'b0;
        a_core_done = 1'b0;
        chk("a_load_beats", acc, 16);
        chk("a_load_cycles", cyc, gaps ? 31 : 16);
        chk("a_no_early_start", early, 0);
        chk("a_start_pulse", a_core_start, 1);
        chk("a_core_pt", a_core_pt, a_model(1'b0));
        chk("a_core_key", a_core_key, a_model(1'b1));
        tick();
        chk("a_start_one_cycle", a_core_start, 0);
    endtask

    task automatic a_unload(input logic [127:0] ct0, input logic [127:0] ct1, input bit bp,
                            input int stop_at, output logic [15:0] first_seen, output logic [15:0] last_seen);
        int beat = 0;
        int cyc = 0;
        bit acc;
        logic [15:0] exp;
        first_seen = 'x;
        last_seen  = 'x;
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        chk("a_wait_ignores_go", {a_in_ready, a_out_valid, a_busy}, 3'b001);
        a_core_ct   = {ct1, ct0};
        a_core_done = 1'b1;
        tick();
        a_core_done = 1'b0;
        a_core_ct   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        chk("a_valid_after_done", a_out_valid, 1);
        while (beat < 16 && beat != stop_at && cyc < 200) begin
            a_out_ready = bp ? 1'($urandom) : 1'b1;
            exp = {ct1[127 - 8*beat -: 8], ct0[127 - 8*beat -: 8]};
            chk("a_out_data", a_out_data, exp);
            chk("a_out_last", a_out_last, beat == 15);
            if (beat == 0) first_seen = a_out_data;
            if (beat == 15) last_seen = a_out_data;
            acc = a_out_valid && a_out_ready;
            tick();
            if (acc) beat++;
            cyc++;
        end
        a_out_ready = 1'b0;
        if (stop_at < 0) begin
            chk("a_unload_beats", beat, 16);
            chk("a_idle_after_last", {a_busy, a_out_valid}, 2'b00);
            chk("a_core_pt_held", a_core_pt, a_model(1'b0));
        end
    endtask

    task automatic a_randomize(input bit zero_data);
        for (int k = 0; k < 16; k++) begin
            a_ptb[k]  = zero_data ? 16'h0 : 16'($urandom);
            a_keyb[k] = zero_data ? 16'h0 : 16'($urandom);
            a_rndb[k] = 16'($urandom) | 16'h0101;
        end
    endtask

    task automatic b_run(input bit bp);
        logic [127:0] ct [3];
        logic [95:0]  got [4];
        logic [95:0]  exp;
        logic [95:0]  held;
        logic [127:0] rec;
        int beat = 0;
        int cyc = 0;
        bit acc;
        bit stalled = 1'b0;
        for (int b = 0; b < 4; b++) begin
            b_ptb[b]  = {$urandom, $urandom, $urandom};
            b_keyb[b] = {$urandom, $urandom, $urandom};
        end
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        chk("b_in_ready_after_go", b_in_ready, 1);
        for (int b = 0; b < 4; b++) begin
            b_in_valid = 1'b1;
            b_pt_in    = b_ptb[b];
            b_key_in   = b_keyb[b];
            b_rnd      = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        b_in_valid = 1'b0;
        chk("b_start_pulse", b_core_start, 1);
        chk("b_core_pt", b_core_pt, b_model(1'b0));
        chk("b_core_key", b_core_key, b_model(1'b1));
        tick();
        for (int s = 0; s < 3; s++) ct[s] = {$urandom, $urandom, $urandom, $urandom};
        b_core_ct   = {ct[2], ct[1], ct[0]};
        b_core_done = 1'b1;
        tick();
        b_core_done = 1'b0;
        b_core_ct   = '0;
        chk("b_valid_after_done", b_out_valid, 1);
        while (beat < 4 && cyc < 100) begin
            b_out_ready = bp ? 1'($urandom) : 1'b1;
            if (stalled) chk("b_hold", b_out_data, held);
            for (int s = 0; s < 3; s++) exp[s*32 +: 32] = ct[s][127 - 32*beat -: 32];
            chk("b_out_data", b_out_data, exp);
            chk("b_out_last", b_out_last, beat == 3);
            acc     = b_out_valid && b_out_ready;
            stalled = b_out_valid && !b_out_ready;
            held    = b_out_data;
            if (acc) got[beat] = b_out_data;
            tick();
            if (acc) beat++;
            cyc++;
        end
        b_out_ready = 1'b0;
        chk("b_unload_beats", beat, 4);
        chk("b_idle_after_last", b_busy, 0);
        rec = '0;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 3; s++) begin
                rec[127 - 32*b -: 32] = rec[127 - 32*b -: 32] ^ got[b][s*32 +: 32];
            end
        end
        chk("b_recombined", rec, ct[0] ^ ct[1] ^ ct[2]);
    endtask

    initial begin
        logic [15:0] first_seen, last_seen;
        kat[0] = '{128'h66E94BD4EF8A2C3B884CFA59CA342B2E, 128'h0, 16'h0066, 16'h002E};
        kat[1] = '{128'h0, 128'h00112233445566778899AABBCCDDEEFF, 16'h0000, 16'hFF00};
        kat[2] = '{128'h0123456789ABCDEFFEDCBA9876543210, {128{1'b1}}, 16'hFF01, 16'hFF10};

        tick();
        tick();
        chk("a_rst_ctrl", {a_in_ready, a_core_start, a_out_valid, a_out_last, a_busy}, 0);
        chk("a_rst_data", {a_core_pt, a_core_key, a_out_data}, 0);
        chk("b_rst_ctrl", {b_in_ready, b_core_start, b_out_valid, b_out_last, b_busy}, 0);
        chk("b_rst_data", {b_core_pt, b_out_data}, 0);
        rst = 1'b0;
        tick();
        chk("a_idle_after_release", {a_in_ready, a_busy, a_out_valid}, 0);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                a_ptb[k]  = 16'h0;
                a_keyb[k] = 16'h0;
                a_rndb[k] = 16'h0;
            end
            a_load(1'b0, 1'b0);
            a_unload(kat[i].ct0, kat[i].ct1, 1'b0, -1, first_seen, last_seen);
            chk("kat_first_beat", first_seen, kat[i].first_beat);
            chk("kat_last_beat", last_seen, kat[i].last_beat);
        end

        a_randomize(1'b1);
        a_load(1'b0, 1'b0);
        chk("a_refresh_pt_xor", a_core_pt[255:128] ^ a_core_pt[127:0], 0);
        chk("a_refresh_key_xor", a_core_key[255:128] ^ a_core_key[127:0], 0);
        chk("a_refresh_share0_nz", a_core_pt[127:0] != 128'h0, 1);
        a_unload({$urandom, $urandom, $urandom, $urandom}, 128'h0, 1'b0, -1, first_seen, last_seen);

        for (int i = 0; i < 3; i++) begin
            a_randomize(1'b0);
            a_load(i == 1, i == 2);
            a_unload({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                     i != 0, -1, first_seen, last_seen);
        end

        a_randomize(1'b0);
        a_load(1'b0, 1'b0);
        a_unload({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 1'b0, 5, first_seen, last_seen);
        chk("a_mid_unload_valid", a_out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("a_mid_rst_ctrl", {a_in_ready, a_core_start, a_out_valid, a_out_last, a_busy}, 0);
        chk("a_mid_rst_data", {a_core_pt, a_core_key, a_out_data}, 0);
        tick();
        rst = 1'b0;
        tick();
        a_randomize(1'b0);
        a_load(1'b1, 1'b0);
        a_unload({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 1'b1, -1, first_seen, last_seen);

        b_run(1'b0);
        b_run(1'b1);
        b_run(1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
